// File: rtl/parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity, stop.
// Completed frames are held with status flags until a valid/ready handshake.
module parity_rx #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              bit_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic ODD_BIT = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                acc_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   shift_d;
  logic                busy_q;

  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                parity_err_q;
  logic                frame_err_q;
  logic                overrun_q;

  logic                frame_done;
  logic                frame_accept;

  always_comb begin
    shift_d = shift_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (cnt_q == CNT_W'(i)) shift_d[i] = rx;
    end
  end

  assign frame_done   = bit_en && (state_q == STOP);
  // A completing frame may replace the held one if it is consumed on the same edge.
  assign frame_accept = frame_done && (!out_valid_q || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      shift_q <= '0;
      busy_q  <= 1'b0;
    end else if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!rx) begin
            state_q <= DATA;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        DATA: begin
          shift_q <= shift_d;
          acc_q   <= acc_q ^ rx;
          if (cnt_q == LAST_BIT) begin
            state_q <= PARITY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PARITY: begin
          acc_q   <= acc_q ^ rx;
          state_q <= STOP;
        end
        STOP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (frame_accept) begin
      out_data_q   <= shift_q;
      out_valid_q  <= 1'b1;
      parity_err_q <= acc_q ^ ODD_BIT;
      frame_err_q  <= ~rx;
      overrun_q    <= 1'b0;
    end else if (frame_done) begin
      overrun_q    <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx: an even-parity and an odd-parity instance share
// the serial line and the ready signal.
module tb_parity_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       bit_en;
  logic       out_ready;

  logic [7:0] evenData;
  logic       evenValid, evenPerr, evenFerr, evenOvr, evenBusy;
  logic [7:0] oddData;
  logic       oddValid, oddPerr, oddFerr, oddOvr, oddBusy;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  parity_rx #(.DATA_W(8), .ODD_PARITY(0)) dutEven (
    .clk(clk), .rst_n(rst_n), .rx(rx), .bit_en(bit_en),
    .out_data(evenData), .out_valid(evenValid), .out_ready(out_ready),
    .parity_err(evenPerr), .frame_err(evenFerr), .overrun(evenOvr), .busy(evenBusy)
  );

  parity_rx #(.DATA_W(8), .ODD_PARITY(1)) dutOdd (
    .clk(clk), .rst_n(rst_n), .rx(rx), .bit_en(bit_en),
    .out_data(oddData), .out_valid(oddValid), .out_ready(out_ready),
    .parity_err(oddPerr), .frame_err(oddFerr), .overrun(oddOvr), .busy(oddBusy)
  );

  // One bit_en strobe per bit; returns on the falling edge right after the sampling edge.
  task automatic send_bit(input logic b);
    @(negedge clk);
    rx     = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
  endtask

  task automatic send_head(input logic [7:0] data, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(par);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    send_head(data, par);
    send_bit(stop);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx = 1'b1; bit_en = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkCount++; if (evenData !== 8'h00) $display("[TB] FAIL reset_data got %h want 00", evenData); else passCount++;
    checkCount++; if (evenValid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", evenValid); else passCount++;
    checkCount++; if (evenPerr !== 1'b0 || evenFerr !== 1'b0) $display("[TB] FAIL reset_flags got %b%b want 00", evenPerr, evenFerr); else passCount++;
    checkCount++; if (evenOvr !== 1'b0) $display("[TB] FAIL reset_overrun got %b want 0", evenOvr); else passCount++;
    checkCount++; if (evenBusy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", evenBusy); else passCount++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkCount++; if (evenBusy !== 1'b0 || evenValid !== 1'b0) $display("[TB] FAIL idle_after_reset got busy=%b valid=%b want 0 0", evenBusy, evenValid); else passCount++;
  endtask

  task automatic test_good_frame;
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1);
    checkCount++; if (evenValid !== 1'b1) $display("[TB] FAIL a5_valid got %b want 1", evenValid); else passCount++;
    checkCount++; if (evenData !== 8'hA5) $display("[TB] FAIL a5_data got %h want a5", evenData); else passCount++;
    checkCount++; if (evenPerr !== 1'b0 || evenFerr !== 1'b0) $display("[TB] FAIL a5_flags got p=%b f=%b want 0 0", evenPerr, evenFerr); else passCount++;
    checkCount++; if (evenBusy !== 1'b0) $display("[TB] FAIL a5_busy got %b want 0", evenBusy); else passCount++;
    @(negedge clk);
    checkCount++; if (evenValid !== 1'b0) $display("[TB] FAIL a5_one_cycle got %b want 0", evenValid); else passCount++;
  endtask

  task automatic test_parity;
    out_ready = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1);
    checkCount++; if (evenData !== 8'h07) $display("[TB] FAIL par07_data got %h want 07", evenData); else passCount++;
    checkCount++; if (evenPerr !== 1'b1) $display("[TB] FAIL par07_even_perr got %b want 1", evenPerr); else passCount++;
    checkCount++; if (oddPerr !== 1'b0) $display("[TB] FAIL par07_odd_perr got %b want 0", oddPerr); else passCount++;
    checkCount++; if (evenValid !== 1'b1 || oddValid !== 1'b1) $display("[TB] FAIL par07_delivered got %b%b want 11", evenValid, oddValid); else passCount++;
    @(negedge clk);
    checkCount++; if (evenPerr !== 1'b0 || evenValid !== 1'b0) $display("[TB] FAIL par07_cleared got p=%b v=%b want 0 0", evenPerr, evenValid); else passCount++;
  endtask

  task automatic test_frame_err;
    out_ready = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0);
    checkCount++; if (evenFerr !== 1'b1) $display("[TB] FAIL ferr_flag got %b want 1", evenFerr); else passCount++;
    checkCount++; if (evenData !== 8'h3C || evenValid !== 1'b1) $display("[TB] FAIL ferr_data got %h v=%b want 3c 1", evenData, evenValid); else passCount++;
    checkCount++; if (evenBusy !== 1'b0) $display("[TB] FAIL ferr_idle got %b want 0", evenBusy); else passCount++;
    send_bit(1'b0);
    checkCount++; if (evenBusy !== 1'b1) $display("[TB] FAIL ferr_restart_busy got %b want 1", evenBusy); else passCount++;
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    checkCount++; if (evenData !== 8'h00 || evenValid !== 1'b1) $display("[TB] FAIL ferr_next_frame got %h v=%b want 00 1", evenData, evenValid); else passCount++;
    checkCount++; if (evenFerr !== 1'b0 || evenPerr !== 1'b0) $display("[TB] FAIL ferr_next_flags got f=%b p=%b want 0 0", evenFerr, evenPerr); else passCount++;
    @(negedge clk);
  endtask

  task automatic test_overrun;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    checkCount++; if (evenValid !== 1'b1 || evenData !== 8'h11) $display("[TB] FAIL ovr_first got %h v=%b want 11 1", evenData, evenValid); else passCount++;
    send_frame(8'h22, 1'b0, 1'b1);
    checkCount++; if (evenData !== 8'h11) $display("[TB] FAIL ovr_data_held got %h want 11", evenData); else passCount++;
    checkCount++; if (evenOvr !== 1'b1) $display("[TB] FAIL ovr_flag got %b want 1", evenOvr); else passCount++;
    checkCount++; if (evenValid !== 1'b1) $display("[TB] FAIL ovr_valid got %b want 1", evenValid); else passCount++;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    checkCount++; if (evenValid !== 1'b0 || evenOvr !== 1'b0) $display("[TB] FAIL ovr_consume got v=%b o=%b want 0 0", evenValid, evenOvr); else passCount++;
    checkCount++; if (evenData !== 8'h11) $display("[TB] FAIL ovr_data_kept got %h want 11", evenData); else passCount++;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_head(8'h22, 1'b0);
    @(negedge clk);
    rx = 1'b1; bit_en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    bit_en = 1'b0; out_ready = 1'b0;
    checkCount++; if (evenData !== 8'h22) $display("[TB] FAIL b2b_data got %h want 22", evenData); else passCount++;
    checkCount++; if (evenValid !== 1'b1) $display("[TB] FAIL b2b_valid got %b want 1", evenValid); else passCount++;
    checkCount++; if (evenOvr !== 1'b0) $display("[TB] FAIL b2b_overrun got %b want 0", evenOvr); else passCount++;
    out_ready = 1'b1;
    @(negedge clk);
    checkCount++; if (evenValid !== 1'b0) $display("[TB] FAIL b2b_drain got %b want 0", evenValid); else passCount++;
  endtask

  task automatic test_reset_mid_frame;
    out_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checkCount++; if (evenBusy !== 1'b1) $display("[TB] FAIL mid_busy_before got %b want 1", evenBusy); else passCount++;
    #2 rst_n = 1'b0;
    #1;
    checkCount++; if (evenBusy !== 1'b0) $display("[TB] FAIL mid_busy_async got %b want 0", evenBusy); else passCount++;
    checkCount++; if (evenData !== 8'h00) $display("[TB] FAIL mid_data_async got %h want 00", evenData); else passCount++;
    checkCount++; if (evenValid !== 1'b0 || evenOvr !== 1'b0) $display("[TB] FAIL mid_valid_async got v=%b o=%b want 0 0", evenValid, evenOvr); else passCount++;
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b1);
    checkCount++; if (evenData !== 8'h81 || evenValid !== 1'b1) $display("[TB] FAIL mid_next_frame got %h v=%b want 81 1", evenData, evenValid); else passCount++;
    checkCount++; if (evenPerr !== 1'b0 || evenFerr !== 1'b0) $display("[TB] FAIL mid_next_flags got p=%b f=%b want 0 0", evenPerr, evenFerr); else passCount++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset;
    test_good_frame;
    test_parity;
    test_frame_err;
    test_overrun;
    test_back_to_back;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
